dcache_nway: RTL and testbench

//  Parametrised N-way set-associative, write-back, write-allocate data cache between datapath and memory arbiter.

---
 rtl/dcache_nway.sv | 268 ++++++++++++++++++++++++++
 tb/tb_dcache_nway.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_nway.sv
// N-way set-associative write-back/write-allocate data cache with true LRU and flush-on-halt.
// Optional DCACHE_HITCOUNT_EN: keep a hit counter and write it to HCTR_ADDR after the flush.
module dcache_nway #(
  parameter int          WAYS        = 2,
  parameter int          SETS        = 8,
  parameter int          BLOCK_WORDS = 2,
  parameter logic [31:0] HCTR_ADDR   = 32'h3100
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        dmemREN,
  input  logic        dmemWEN,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemstore,
  input  logic        halt,
  output logic        dhit,
  output logic [31:0] dmemload,
  output logic        flushed,
  output logic        dREN,
  output logic        dWEN,
  output logic [31:0] daddr,
  output logic [31:0] dstore,
  input  logic [31:0] dload,
  input  logic        dwait
);

  localparam int BO = $clog2(BLOCK_WORDS);
  localparam int IX = $clog2(SETS);
  localparam int TW = 30 - BO - IX;
  localparam int OW = (BO > 0) ? BO : 1;
  localparam int WW = (WAYS > 1) ? $clog2(WAYS) : 1;

  localparam logic [2:0] ACCESS     = 3'd0;
  localparam logic [2:0] WB         = 3'd1;
  localparam logic [2:0] FILL       = 3'd2;
  localparam logic [2:0] FLUSH_SCAN = 3'd3;
  localparam logic [2:0] FLUSH_WB   = 3'd4;
  localparam logic [2:0] HALT       = 3'd6;
`ifdef DCACHE_HITCOUNT_EN
  localparam logic [2:0] HCTR       = 3'd5;
  localparam logic [2:0] SCAN_DONE  = HCTR;
`else
  localparam logic [2:0] SCAN_DONE  = HALT;
`endif

  logic          line_valid [SETS][WAYS];
  logic          line_dirty [SETS][WAYS];
  logic [TW-1:0] line_tag   [SETS][WAYS];
  logic [31:0]   line_data  [SETS][WAYS][BLOCK_WORDS];
  logic [WW-1:0] age        [SETS][WAYS];

  logic [2:0]    state;
  logic [OW-1:0] w;
  logic [WW-1:0] victim;
  logic [TW-1:0] miss_tag;
  logic [IX-1:0] miss_idx;
  logic [IX-1:0] scan_set;
  logic [WW-1:0] scan_way;

  logic [TW-1:0] req_tag;
  logic [IX-1:0] req_idx;
  logic [OW-1:0] req_off;
  logic          hit_any;
  logic [WW-1:0] hit_way;
  logic [WW-1:0] vict_way;
  logic [WW-1:0] vict_age;
  logic          in_access, req, hit_now, miss_now;
  logic          w_last, scan_last, fill_done, scan_adv;
  logic          touch_en;
  logic [IX-1:0] touch_set;
  logic [WW-1:0] touch_way;

  assign req_tag = dmemaddr[31 -: TW];
  assign req_idx = dmemaddr[2+BO +: IX];
  assign req_off = OW'(dmemaddr[31:2] & 30'(BLOCK_WORDS - 1));

  function automatic logic [31:0] word_addr(input logic [TW-1:0] t, input logic [IX-1:0] s,
                                            input logic [OW-1:0] o);
    return (32'(t) << (2 + BO + IX)) | (32'(s) << (2 + BO)) | (32'(o) << 2);
  endfunction

  // Victim: lowest-numbered invalid way wins over the oldest valid way.
  always_comb begin
    hit_any  = 1'b0;
    hit_way  = '0;
    vict_way = '0;
    vict_age = age[req_idx][0];
    for (int i = 0; i < WAYS; i++) begin
      if (line_valid[req_idx][i] && line_tag[req_idx][i] == req_tag) begin
        hit_any = 1'b1;
        hit_way = WW'(i);
      end
    end
    for (int i = 1; i < WAYS; i++) begin
      if (age[req_idx][i] > vict_age) begin
        vict_age = age[req_idx][i];
        vict_way = WW'(i);
      end
    end
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (!line_valid[req_idx][i]) vict_way = WW'(i);
    end
  end

  assign in_access = (state == ACCESS) && !halt;
  assign req       = dmemREN | dmemWEN;
  assign hit_now   = in_access && req && hit_any;
  assign miss_now  = in_access && req && !hit_any;
  assign w_last    = (w == OW'(BLOCK_WORDS - 1));
  assign scan_last = (scan_set == IX'(SETS - 1)) && (scan_way == WW'(WAYS - 1));
  assign fill_done = (state == FILL) && !dwait && w_last;
  assign scan_adv  = ((state == FLUSH_SCAN) && !line_dirty[scan_set][scan_way]) ||
                     ((state == FLUSH_WB) && !dwait && w_last);
  assign touch_en  = hit_now || fill_done;
  assign touch_set = hit_now ? req_idx : miss_idx;
  assign touch_way = hit_now ? hit_way : victim;

`ifdef DCACHE_HITCOUNT_EN
  logic [31:0] hit_count;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) hit_count <= '0;
    else if (hit_now) hit_count <= hit_count + 32'd1;
    else if (miss_now) hit_count <= hit_count - 32'd1;
  end
`endif

  always_comb begin
    dhit     = 1'b0;
    dmemload = '0;
    flushed  = 1'b0;
    dREN     = 1'b0;
    dWEN     = 1'b0;
    daddr    = '0;
    dstore   = '0;
    case (state)
      ACCESS: begin
        dhit = hit_now;
        if (hit_now && dmemREN) dmemload = line_data[req_idx][hit_way][req_off];
      end
      WB: begin
        dWEN   = 1'b1;
        daddr  = word_addr(line_tag[miss_idx][victim], miss_idx, w);
        dstore = line_data[miss_idx][victim][w];
      end
      FILL: begin
        dREN  = 1'b1;
        daddr = word_addr(miss_tag, miss_idx, w);
      end
      FLUSH_WB: begin
        dWEN   = 1'b1;
        daddr  = word_addr(line_tag[scan_set][scan_way], scan_set, w);
        dstore = line_data[scan_set][scan_way][w];
      end
`ifdef DCACHE_HITCOUNT_EN
      HCTR: begin
        dWEN   = 1'b1;
        daddr  = HCTR_ADDR;
        dstore = hit_count;
      end
`endif
      HALT: flushed = 1'b1;
      default: ;
    endcase
  end

  // Line storage, LRU ages and the controller share one register block.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= ACCESS;
      w        <= '0;
      victim   <= '0;
      miss_tag <= '0;
      miss_idx <= '0;
      scan_set <= '0;
      scan_way <= '0;
      for (int s = 0; s < SETS; s++) begin
        for (int i = 0; i < WAYS; i++) begin
          line_valid[s][i] <= 1'b0;
          line_dirty[s][i] <= 1'b0;
          line_tag[s][i]   <= '0;
          age[s][i]        <= WW'(i);
          for (int k = 0; k < BLOCK_WORDS; k++) line_data[s][i][k] <= '0;
        end
      end
    end else begin
      if (touch_en) begin
        for (int i = 0; i < WAYS; i++) begin
          if (WW'(i) == touch_way) age[touch_set][i] <= '0;
          else if (age[touch_set][i] < age[touch_set][touch_way])
            age[touch_set][i] <= age[touch_set][i] + 1'b1;
        end
      end
      case (state)
        ACCESS: begin
          if (halt) begin
            state    <= FLUSH_SCAN;
            scan_set <= '0;
            scan_way <= '0;
          end else if (hit_now) begin
            if (dmemWEN && !dmemREN) begin
              line_data[req_idx][hit_way][req_off] <= dmemstore;
              line_dirty[req_idx][hit_way]         <= 1'b1;
            end
          end else if (miss_now) begin
            victim   <= vict_way;
            miss_tag <= req_tag;
            miss_idx <= req_idx;
            w        <= '0;
            state    <= line_dirty[req_idx][vict_way] ? WB : FILL;
          end
        end
        WB: begin
          if (!dwait) begin
            if (w_last) begin
              line_dirty[miss_idx][victim] <= 1'b0;
              w     <= '0;
              state <= FILL;
            end else w <= w + 1'b1;
          end
        end
        FILL: begin
          if (!dwait) begin
            line_data[miss_idx][victim][w] <= dload;
            if (w_last) begin
              line_valid[miss_idx][victim] <= 1'b1;
              line_dirty[miss_idx][victim] <= 1'b0;
              line_tag[miss_idx][victim]   <= miss_tag;
              w     <= '0;
              state <= ACCESS;
            end else w <= w + 1'b1;
          end
        end
        FLUSH_SCAN: begin
          if (line_dirty[scan_set][scan_way]) begin
            w     <= '0;
            state <= FLUSH_WB;
          end
        end
        FLUSH_WB: begin
          if (!dwait) begin
            if (w_last) begin
              line_dirty[scan_set][scan_way] <= 1'b0;
              w <= '0;
            end else w <= w + 1'b1;
          end
        end
`ifdef DCACHE_HITCOUNT_EN
        HCTR: if (!dwait) state <= HALT;
`endif
        HALT: ;
        default: state <= ACCESS;
      endcase
      // Step the scan pointer set-major, way-minor after a clean line or a finished write-back.
      if (scan_adv) begin
        if (scan_last) state <= SCAN_DONE;
        else begin
          state <= FLUSH_SCAN;
          if (scan_way == WW'(WAYS - 1)) begin
            scan_way <= '0;
            scan_set <= scan_set + 1'b1;
          end else scan_way <= scan_way + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dcache_nway.sv
// Self-checking bench for dcache_nway: directed vector table, latency/abort/flush sequences,
// and randomized traffic against a timestamp-LRU reference model with its own memory image.
module tb_dcache_nway;

  localparam int WAYS = 2;
  localparam int SETS = 8;
  localparam int BW   = 2;
  localparam logic [31:0] HCTR_A = 32'h3100;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        dmemREN = 1'b0, dmemWEN = 1'b0, halt = 1'b0;
  logic [31:0] dmemaddr = '0, dmemstore = '0;
  logic        dhit, flushed, dREN, dWEN;
  logic [31:0] dmemload, daddr, dstore;
  logic [31:0] dload = '0;
  logic        dwait = 1'b1;

  dcache_nway #(.WAYS(WAYS), .SETS(SETS), .BLOCK_WORDS(BW), .HCTR_ADDR(HCTR_A)) dut (
    .CLK(CLK), .nRST(nRST), .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr),
    .dmemstore(dmemstore), .halt(halt), .dhit(dhit), .dmemload(dmemload), .flushed(flushed),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dload(dload), .dwait(dwait)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic        wen;
    logic [31:0] addr;
    logic [31:0] data;
  } xfer_t;

  typedef struct {
    bit          rd;
    logic [31:0] addr;
    logic [31:0] wd;
    bit          ehit;
    logic [31:0] eload;
    int          enx;
    bit          ex0wen;
    logic [31:0] ex0addr;
  } vec_t;

  int n_checks = 0;
  int n_pass = 0;
  int lat = 0;
  int cnt = 0;
  int unstable = 0;
  logic [31:0] pend_addr = '0;
  logic        pend_wen = 1'b0;
  xfer_t log_q[$];
  xfer_t exp_q[$];
  logic [31:0] mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];

  bit          m_valid [SETS][WAYS];
  bit          m_dirty [SETS][WAYS];
  int unsigned m_tag   [SETS][WAYS];
  logic [31:0] m_data  [SETS][WAYS][BW];
  longint      m_stamp [SETS][WAYS];
  longint      m_now;
  logic [31:0] m_hits;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h13572468;
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  // Memory side: decide dwait for the current request mid-cycle; commits happen at the next edge.
  always @(negedge CLK) begin
    if (!nRST) begin
      cnt   = 0;
      dwait = 1'b1;
    end else if (dREN || dWEN) begin
      if (cnt > 0 && (daddr != pend_addr || dWEN != pend_wen)) unstable++;
      if (dhit) unstable++;
      pend_addr = daddr;
      pend_wen  = dWEN;
      dload = mem_rd(daddr);
      dwait = (cnt < lat);
      if (!dwait) begin
        log_q.push_back('{wen: dWEN, addr: daddr, data: (dWEN ? dstore : dload)});
        if (dWEN) mem[daddr] = dstore;
        cnt = 0;
      end else cnt++;
    end else begin
      dwait = 1'b1;
      cnt   = 0;
    end
  end

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic model_reset();
    for (int s = 0; s < SETS; s++)
      for (int i = 0; i < WAYS; i++) begin
        m_valid[s][i] = 0;
        m_dirty[s][i] = 0;
        m_tag[s][i]   = 0;
        m_stamp[s][i] = WAYS - i;
        for (int k = 0; k < BW; k++) m_data[s][i][k] = '0;
      end
    m_now  = WAYS + 1;
    m_hits = '0;
    exp_q.delete();
  endtask

  task automatic model_access(input bit rd, input logic [31:0] addr, input logic [31:0] wd,
                              output bit ehit, output logic [31:0] eload);
    int unsigned t;
    int s, o, w;
    logic [31:0] base;
    t = addr / (SETS * BW * 4);
    s = (addr / (BW * 4)) % SETS;
    o = (addr / 4) % BW;
    w = -1;
    for (int i = 0; i < WAYS; i++) if (m_valid[s][i] && m_tag[s][i] == t) w = i;
    ehit = (w >= 0);
    if (w < 0) begin
      for (int i = WAYS - 1; i >= 0; i--) if (!m_valid[s][i]) w = i;
      if (w < 0) begin
        w = 0;
        for (int i = 1; i < WAYS; i++) if (m_stamp[s][i] < m_stamp[s][w]) w = i;
      end
      if (m_valid[s][w] && m_dirty[s][w]) begin
        base = (m_tag[s][w] * SETS + s) * BW * 4;
        for (int k = 0; k < BW; k++) begin
          exp_q.push_back('{wen: 1'b1, addr: base + 4 * k, data: m_data[s][w][k]});
          ref_mem[base + 4 * k] = m_data[s][w][k];
        end
      end
      base = (t * SETS + s) * BW * 4;
      for (int k = 0; k < BW; k++) begin
        m_data[s][w][k] = ref_rd(base + 4 * k);
        exp_q.push_back('{wen: 1'b0, addr: base + 4 * k, data: m_data[s][w][k]});
      end
      m_valid[s][w] = 1;
      m_dirty[s][w] = 0;
      m_tag[s][w]   = t;
      m_hits        = m_hits - 1;
    end
    m_stamp[s][w] = m_now++;
    m_hits        = m_hits + 1;
    if (rd) eload = m_data[s][w][o];
    else begin
      m_data[s][w][o] = wd;
      m_dirty[s][w]   = 1;
      eload           = '0;
    end
  endtask

  task automatic model_flush();
    logic [31:0] base;
    for (int s = 0; s < SETS; s++)
      for (int i = 0; i < WAYS; i++)
        if (m_valid[s][i] && m_dirty[s][i]) begin
          base = (m_tag[s][i] * SETS + s) * BW * 4;
          for (int k = 0; k < BW; k++) begin
            exp_q.push_back('{wen: 1'b1, addr: base + 4 * k, data: m_data[s][i][k]});
            ref_mem[base + 4 * k] = m_data[s][i][k];
          end
          m_dirty[s][i] = 0;
        end
`ifdef DCACHE_HITCOUNT_EN
    exp_q.push_back('{wen: 1'b1, addr: HCTR_A, data: m_hits});
`endif
  endtask

  task automatic compare_xfers(input string name);
    check_output({name, "_nxfer"}, 64'(log_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < log_q.size() && i < exp_q.size(); i++) begin
      check_output({name, "_xaddr"}, {log_q[i].wen, log_q[i].addr}, {exp_q[i].wen, exp_q[i].addr});
      check_output({name, "_xdata"}, log_q[i].data, exp_q[i].data);
    end
    log_q.delete();
    exp_q.delete();
  endtask

  task automatic check_idle_outputs(input string name);
    check_output({name, "_ctl"}, {dhit, dREN, dWEN, flushed}, 4'b0000);
    check_output({name, "_daddr"}, daddr, 32'h0);
    check_output({name, "_dstore"}, dstore, 32'h0);
    check_output({name, "_load"}, dmemload, 32'h0);
  endtask

  task automatic do_reset(input bit check);
    nRST = 1'b0;
    halt = 1'b0;
    dmemREN = 1'b0;
    dmemWEN = 1'b0;
    @(posedge CLK);
    #1;
    if (check) check_idle_outputs("reset");
    @(negedge CLK);
    nRST = 1'b1;
    model_reset();
    log_q.delete();
    @(posedge CLK);
    #1;
    if (check) check_idle_outputs("post_reset");
  endtask

  task automatic apply_stimulus(input bit rd, input logic [31:0] addr, input logic [31:0] wd,
                                output bit first, output logic [31:0] load, output int cyc);
    bit got = 0;
    dmemREN   = rd;
    dmemWEN   = !rd;
    dmemaddr  = addr;
    dmemstore = wd;
    cyc = 0;
    first = 0;
    load = '0;
    for (int i = 0; i < 400; i++) begin
      @(negedge CLK);
      if (dhit) begin
        first = (cyc == 0);
        load  = dmemload;
        got   = 1;
        break;
      end
      cyc++;
    end
    if (!got) check_output("op_timeout", 64'd0, 64'd1);
    @(posedge CLK);
    #1;
    dmemREN = 1'b0;
    dmemWEN = 1'b0;
  endtask

  task automatic wait_flushed(output int n);
    bit got = 0;
    n = 0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge CLK);
      n++;
      @(negedge CLK);
      if (flushed) begin
        got = 1;
        break;
      end
    end
    if (!got) check_output("flush_timeout", 64'd0, 64'd1);
  endtask

  vec_t vecs[9];

  initial begin
    bit first, ehit;
    logic [31:0] load, eload;
    int cyc, n;

    vecs[0] = '{1, 32'h100, 0,           0, 32'hA5,           2, 0, 32'h100};
    vecs[1] = '{1, 32'h040, 0,           0, init_word(32'h40),  2, 0, 32'h040};
    vecs[2] = '{1, 32'h104, 0,           1, init_word(32'h104), 0, 0, 32'h0};
    vecs[3] = '{1, 32'h080, 0,           0, init_word(32'h80),  2, 0, 32'h080};
    vecs[4] = '{1, 32'h040, 0,           0, init_word(32'h40),  2, 0, 32'h040};
    vecs[5] = '{0, 32'h084, 32'hDEAD,    1, 32'h0,             0, 0, 32'h0};
    vecs[6] = '{1, 32'h100, 0,           0, 32'hA5,            2, 0, 32'h100};
    vecs[7] = '{1, 32'h0C0, 0,           0, init_word(32'hC0),  4, 1, 32'h080};
    vecs[8] = '{1, 32'h084, 0,           0, 32'hDEAD,          2, 0, 32'h080};

    mem[32'h100]     = 32'hA5;
    ref_mem[32'h100] = 32'hA5;
    do_reset(1);

    // Directed table: first fill, LRU eviction of a clean line, dirty write-back and refetch.
    lat = 0;
    foreach (vecs[i]) begin
      model_access(vecs[i].rd, vecs[i].addr, vecs[i].wd, ehit, eload);
      apply_stimulus(vecs[i].rd, vecs[i].addr, vecs[i].wd, first, load, cyc);
      check_output($sformatf("vec%0d_hit", i), 64'(first), 64'(vecs[i].ehit));
      if (vecs[i].rd) check_output($sformatf("vec%0d_load", i), load, vecs[i].eload);
      check_output($sformatf("vec%0d_nx", i), 64'(log_q.size()), 64'(vecs[i].enx));
      if (vecs[i].enx > 0 && log_q.size() > 0)
        check_output($sformatf("vec%0d_x0", i), {log_q[0].wen, log_q[0].addr},
                     {vecs[i].ex0wen, vecs[i].ex0addr});
      compare_xfers($sformatf("vec%0d", i));
    end

    // Slow memory: requests held stable, no dhit until the fill is done.
    lat = 5;
    unstable = 0;
    model_access(1, 32'h208, 0, ehit, eload);
    apply_stimulus(1, 32'h208, 0, first, load, cyc);
    check_output("slow_first", 64'(first), 64'd0);
    check_output("slow_cycles", 64'(cyc), 64'(1 + 2 * 6));
    check_output("slow_load", load, eload);
    check_output("slow_stable", 64'(unstable), 64'd0);
    compare_xfers("slow");

    // Reset in the middle of a fill aborts it and leaves the line invalid.
    dmemREN  = 1'b1;
    dmemaddr = 32'h310;
    repeat (4) @(posedge CLK);
    #2;
    check_output("abort_busy", 64'(dREN), 64'd1);
    nRST = 1'b0;
    #1;
    check_idle_outputs("abort");
    dmemREN = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
    model_reset();
    log_q.delete();
    @(posedge CLK);
    #1;
    lat = 0;
    model_access(1, 32'h310, 0, ehit, eload);
    apply_stimulus(1, 32'h310, 0, first, load, cyc);
    check_output("abort_refetch_hit", 64'(first), 64'd0);
    check_output("abort_refetch_load", load, eload);
    compare_xfers("abort");

    // Random traffic over a few conflicting tags per set.
    unstable = 0;
    for (int k = 0; k < 250; k++) begin
      bit rd;
      logic [31:0] addr, wd;
      lat  = $urandom_range(0, 2);
      rd   = 1'($urandom_range(0, 1));
      addr = 32'($urandom_range(0, 6 * SETS * BW - 1)) * 4;
      wd   = $urandom;
      model_access(rd, addr, wd, ehit, eload);
      apply_stimulus(rd, addr, wd, first, load, cyc);
      check_output($sformatf("rnd%0d_hit", k), 64'(first), 64'(ehit));
      if (rd) check_output($sformatf("rnd%0d_load", k), load, eload);
      compare_xfers($sformatf("rnd%0d", k));
    end
    check_output("rnd_stable", 64'(unstable), 64'd0);

    // Halt flushes every dirty line in set-major order, then reports hits if enabled.
    lat = 1;
    model_flush();
    halt = 1'b1;
    wait_flushed(n);
    compare_xfers("flush");
    repeat (5) @(posedge CLK);
    #1;
    check_output("flush_held", {flushed, dREN, dWEN}, 3'b100);
    check_output("flush_quiet", 64'(log_q.size()), 64'd0);

    // Clean-cache halt: one scan cycle per line plus the transition.
    do_reset(0);
    lat = 0;
    model_flush();
    halt = 1'b1;
    wait_flushed(n);
`ifdef DCACHE_HITCOUNT_EN
    check_output("clean_flush_cycles", 64'(n), 64'(SETS * WAYS + 2));
`else
    check_output("clean_flush_cycles", 64'(n), 64'(SETS * WAYS + 1));
`endif
    compare_xfers("clean_flush");
    halt = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
